// File: rtl/serial_checking_sink_if.sv
// ============================================================================
//  Module      : serial_checking_sink_if
//  Description : Router-output-to-sink bundle: serial flit line in, backpressure
//                and receive statistics out.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface serial_checking_sink_if #(
    parameter int FLIT_WIDTH = 16
);
    logic                  serial_in;
    logic                  channel_busy;
    logic                  flit_valid;
    logic [FLIT_WIDTH-1:0] flit_data;
    logic [19:0]           flit_count;
    logic [15:0]           err_count;
    logic [15:0]           proto_err;
    logic                  misroute;

    // Router side: drives the serial line, observes the sink.
    modport master (
        output serial_in,
        input  channel_busy,
        input  flit_valid,
        input  flit_data,
        input  flit_count,
        input  err_count,
        input  proto_err,
        input  misroute
    );

    // Sink side.
    modport slave (
        input  serial_in,
        output channel_busy,
        output flit_valid,
        output flit_data,
        output flit_count,
        output err_count,
        output proto_err,
        output misroute
    );
endinterface

`default_nettype wire

// File: rtl/serial_checking_sink.sv
// ============================================================================
//  Module      : serial_checking_sink
//  Description : Endpoint for one router output port. Deserializes start-bit
//                framed flits (LSB first), checks the destination field against
//                the sink id, keeps saturating flit / error / protocol counters
//                and inserts LFSR-driven stalls gated by HOSPITALITY.
//  Options     : `define PARITY_CHECK_EN adds an even-parity bit after the data.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module serial_checking_sink #(
    parameter int         id          = 0,
    parameter int         FLIT_WIDTH  = 16,
    parameter int         DEST_LSB    = 0,
    parameter int         DEST_WIDTH  = 4,
    parameter int         HOSPITALITY = 255,
    parameter logic [7:0] SEED        = 8'hA5
) (
    input  wire logic               clk,
    input  wire logic               reset,
    serial_checking_sink_if.slave   bus
);

    localparam int CNT_W = $clog2(FLIT_WIDTH) + 1;
`ifdef PARITY_CHECK_EN
    localparam int LAST_BIT = FLIT_WIDTH;        // parity bit follows the data
`else
    localparam int LAST_BIT = FLIT_WIDTH - 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2,
        S_STALL = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [FLIT_WIDTH-1:0] shift_q, shift_d;
    logic [FLIT_WIDTH-1:0] flit_data_q, flit_data_d;
    logic                  parity_ok_q, parity_ok_d;
    logic [7:0]            lfsr_q, lfsr_d;
    logic [19:0]           flit_count_q, flit_count_d;
    logic [15:0]           err_count_q, err_count_d;
    logic [15:0]           proto_err_q, proto_err_d;
    logic                  misroute_q, misroute_d;
    logic [7:0]            lfsr_next;
    logic                  parity_good;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4 (maximal length, never reaches zero).
    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

`ifdef PARITY_CHECK_EN
    // Even parity: the parity bit equals the XOR of all data bits.
    assign parity_good = ((^shift_q) == bus.serial_in);
`else
    assign parity_good = 1'b1;
`endif

    // Next-state and counter update logic.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        flit_data_d  = flit_data_q;
        parity_ok_d  = parity_ok_q;
        lfsr_d       = lfsr_q;
        flit_count_d = flit_count_q;
        err_count_d  = err_count_q;
        proto_err_d  = proto_err_q;
        misroute_d   = misroute_q;

        case (state_q)
            S_IDLE: begin
                if (bus.serial_in) begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = '0;
                end
            end

            S_SHIFT: begin
                // The parity bit position (if any) is beyond the data register.
                if (bit_cnt_q < CNT_W'(FLIT_WIDTH)) begin
                    shift_d[bit_cnt_q[CNT_W-2:0]] = bus.serial_in;
                end
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_W'(LAST_BIT)) begin
                    // Publish the flit so it is valid in the same cycle as the pulse.
                    state_d     = S_DONE;
                    flit_data_d = shift_d;
                    parity_ok_d = parity_good;
                end
            end

            S_DONE: begin
                lfsr_d  = lfsr_next;
                state_d = S_STALL;
                if (parity_ok_q) begin
                    if (flit_count_q != '1) flit_count_d = flit_count_q + 1'b1;
                    if (flit_data_q[DEST_LSB +: DEST_WIDTH] != DEST_WIDTH'(id)) begin
                        if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
                        misroute_d = 1'b1;
                    end
                end else begin
                    if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
                end
            end

            S_STALL: begin
                // A start bit while we are still busy is a sender violation; it is dropped.
                if (bus.serial_in && (proto_err_q != '1)) proto_err_d = proto_err_q + 1'b1;
                if (int'(lfsr_q) > HOSPITALITY) begin
                    lfsr_d = lfsr_next;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            flit_data_q  <= '0;
            parity_ok_q  <= 1'b0;
            lfsr_q       <= SEED;
            flit_count_q <= '0;
            err_count_q  <= '0;
            proto_err_q  <= '0;
            misroute_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            flit_data_q  <= flit_data_d;
            parity_ok_q  <= parity_ok_d;
            lfsr_q       <= lfsr_d;
            flit_count_q <= flit_count_d;
            err_count_q  <= err_count_d;
            proto_err_q  <= proto_err_d;
            misroute_q   <= misroute_d;
        end
    end

    // Busy covers the whole frame, the DONE cycle and any stall.
    assign bus.channel_busy = (state_q != S_IDLE);
    assign bus.flit_valid   = (state_q == S_DONE) && parity_ok_q;
    assign bus.flit_data    = flit_data_q;
    assign bus.flit_count   = flit_count_q;
    assign bus.err_count    = err_count_q;
    assign bus.proto_err    = proto_err_q;
    assign bus.misroute     = misroute_q;

endmodule

`default_nettype wire
